// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared encodings and widths for the regfile write-port arbiter.
package regfile_wport_arbiter_pkg;

  localparam int unsigned STATE_DW = 18;
  localparam int unsigned INEX_DW  = 32;
  localparam int unsigned AW       = 12;

  localparam logic SEL_STATE = 1'b0;
  localparam logic SEL_INEX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_STALL_REQ = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_wport_arbiter_wr_fifo.sv
// Host write queue: synchronous FIFO with first-word fall-through head.
module regfile_wport_arbiter_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 45
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_wdata,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A full queue never accepts, even if the head leaves in the same cycle.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the state / InexRecur random write ports between accelerator
// write-back (always wins) and a queued host loader drained into idle cycles.
module regfile_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned AW         = regfile_wport_arbiter_pkg::AW
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           acc_we_state_i,
  input  logic [AW-1:0]                                  acc_waddr_state_i,
  input  logic [regfile_wport_arbiter_pkg::STATE_DW-1:0] acc_wdata_state_i,
  input  logic                                           acc_we_inex_i,
  input  logic [AW-1:0]                                  acc_waddr_inex_i,
  input  logic [regfile_wport_arbiter_pkg::INEX_DW-1:0]  acc_wdata_inex_i,
  input  logic                                           host_wvalid_i,
  output logic                                           host_wready_o,
  input  logic                                           host_wsel_i,
  input  logic [AW-1:0]                                  host_waddr_i,
  input  logic [regfile_wport_arbiter_pkg::INEX_DW-1:0]  host_wdata_i,
  output logic                                           ran_we_state_o,
  output logic [AW-1:0]                                  ran_w_addr_state_o,
  output logic [regfile_wport_arbiter_pkg::STATE_DW-1:0] ran_w_data_state_o,
  output logic                                           ran_we_InexRecur_o,
  output logic [AW-1:0]                                  ran_w_addr_InexRecur_o,
  output logic [regfile_wport_arbiter_pkg::INEX_DW-1:0]  ran_w_data_InexRecur_o,
  output logic                                           acc_stall_o,
  output logic [$clog2(FIFO_DEPTH):0]                    host_pending_o,
  output logic                                           conflict_o
);

  import regfile_wport_arbiter_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned EW = 1 + AW + INEX_DW;

  typedef struct packed {
    logic               sel;
    logic [AW-1:0]      addr;
    logic [INEX_DW-1:0] data;
  } host_wr_t;

  host_wr_t      w_push_entry;
  host_wr_t      w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;
  logic          w_head_blocked;
  logic          w_grant_state;
  logic          w_grant_inex;

  arb_state_t    r_state;
  logic [SW-1:0] r_starve;
  logic          r_acc_stall;
  logic          r_conflict;

  assign w_push_entry = '{sel: host_wsel_i, addr: host_waddr_i, data: host_wdata_i};

  regfile_wport_arbiter_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (EW)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Host handshake: accept whenever the queue has room.
  assign host_wready_o = !w_full;
  assign w_push        = host_wvalid_i && !w_full;

  // Head is eligible only when it exists; a head being flushed by reset never writes.
  assign w_head_valid   = !w_empty && !rst;
  // Only the write enable of the head's own target file can block it.
  assign w_head_blocked = (w_head.sel == SEL_INEX) ? acc_we_inex_i : acc_we_state_i;
  assign w_grant_state  = w_head_valid && (w_head.sel == SEL_STATE) && !acc_we_state_i;
  assign w_grant_inex   = w_head_valid && (w_head.sel == SEL_INEX) && !acc_we_inex_i;
  assign w_pop          = w_grant_state || w_grant_inex;

  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  // Port mux: write-back passes straight through, else the granted head, else idle zeros.
  always_comb begin
    ran_we_state_o         = acc_we_state_i || w_grant_state;
    ran_w_addr_state_o     = '0;
    ran_w_data_state_o     = '0;
    ran_we_InexRecur_o     = acc_we_inex_i || w_grant_inex;
    ran_w_addr_InexRecur_o = '0;
    ran_w_data_InexRecur_o = '0;
    if (acc_we_state_i) begin
      ran_w_addr_state_o = acc_waddr_state_i;
      ran_w_data_state_o = acc_wdata_state_i;
    end else if (w_grant_state) begin
      ran_w_addr_state_o = w_head.addr;
      ran_w_data_state_o = w_head.data[STATE_DW-1:0];
    end
    if (acc_we_inex_i) begin
      ran_w_addr_InexRecur_o = acc_waddr_inex_i;
      ran_w_data_InexRecur_o = acc_wdata_inex_i;
    end else if (w_grant_inex) begin
      ran_w_addr_InexRecur_o = w_head.addr;
      ran_w_data_InexRecur_o = w_head.data;
    end
  end

  // Drain FSM with saturating starvation counter, registered stall pulse and sticky conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_starve    <= '0;
      r_acc_stall <= 1'b0;
      r_conflict  <= 1'b0;
    end else begin
      r_acc_stall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (w_push) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_starve <= '0;
            r_state  <= (w_count_nxt == '0) ? ST_IDLE : ST_DRAIN;
          end else if (w_head_valid) begin
            if (r_starve >= SW'(STARVE_MAX - 1)) begin
              r_starve    <= SW'(STARVE_MAX);
              r_state     <= ST_STALL_REQ;
              r_acc_stall <= 1'b1;
            end else begin
              r_starve <= r_starve + SW'(1);
            end
          end else begin
            r_starve <= '0;
            r_state  <= ST_IDLE;
          end
        end
        ST_STALL_REQ: begin
          // Head was granted; if write-back ignored the stall it still wins.
          r_starve <= '0;
          if (w_head_valid && w_head_blocked) begin
            r_conflict <= 1'b1;
          end
          r_state <= (w_count_nxt != '0) ? ST_DRAIN : ST_IDLE;
        end
        default: begin
          r_starve <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign acc_stall_o    = r_acc_stall;
  assign conflict_o     = r_conflict;
  assign host_pending_o = w_count;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: directed stimulus, monitor checks port writes.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_we_state_i;
  logic [11:0] acc_waddr_state_i;
  logic [17:0] acc_wdata_state_i;
  logic        acc_we_inex_i;
  logic [11:0] acc_waddr_inex_i;
  logic [31:0] acc_wdata_inex_i;
  logic        host_wvalid_i;
  logic        host_wready_o;
  logic        host_wsel_i;
  logic [11:0] host_waddr_i;
  logic [31:0] host_wdata_i;
  logic        ran_we_state_o;
  logic [11:0] ran_w_addr_state_o;
  logic [17:0] ran_w_data_state_o;
  logic        ran_we_InexRecur_o;
  logic [11:0] ran_w_addr_InexRecur_o;
  logic [31:0] ran_w_data_InexRecur_o;
  logic        acc_stall_o;
  logic [2:0]  host_pending_o;
  logic        conflict_o;

  typedef struct packed {
    logic        sel;
    logic [11:0] addr;
    logic [31:0] data;
  } hw_t;

  hw_t hq[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .FIFO_DEPTH (4),
    .STARVE_MAX (8),
    .AW         (12)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .acc_we_state_i         (acc_we_state_i),
    .acc_waddr_state_i      (acc_waddr_state_i),
    .acc_wdata_state_i      (acc_wdata_state_i),
    .acc_we_inex_i          (acc_we_inex_i),
    .acc_waddr_inex_i       (acc_waddr_inex_i),
    .acc_wdata_inex_i       (acc_wdata_inex_i),
    .host_wvalid_i          (host_wvalid_i),
    .host_wready_o          (host_wready_o),
    .host_wsel_i            (host_wsel_i),
    .host_waddr_i           (host_waddr_i),
    .host_wdata_i           (host_wdata_i),
    .ran_we_state_o         (ran_we_state_o),
    .ran_w_addr_state_o     (ran_w_addr_state_o),
    .ran_w_data_state_o     (ran_w_data_state_o),
    .ran_we_InexRecur_o     (ran_we_InexRecur_o),
    .ran_w_addr_InexRecur_o (ran_w_addr_InexRecur_o),
    .ran_w_data_InexRecur_o (ran_w_data_InexRecur_o),
    .acc_stall_o            (acc_stall_o),
    .host_pending_o         (host_pending_o),
    .conflict_o             (conflict_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host write seen on a port: must be the oldest outstanding queued write.
  task automatic host_seen(input logic sel, input logic [11:0] addr, input logic [31:0] data);
    hw_t e;
    logic [31:0] exp_data;
    if (hq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_host_write: got sel=%0d addr=0x%0h data=0x%0h expected none at %0t",
               sel, addr, data, $time);
    end else begin
      e = hq.pop_front();
      exp_data = e.sel ? e.data : {14'b0, e.data[17:0]};
      chk("host_write", {19'b0, sel, addr, data}, {19'b0, e.sel, e.addr, exp_data});
    end
  endtask

  // Monitor: write-back must pass through unchanged; any other port write is a host write.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_we_state_i) begin
        chk("acc_state_pass", 64'({ran_we_state_o, ran_w_addr_state_o, ran_w_data_state_o}),
            64'({1'b1, acc_waddr_state_i, acc_wdata_state_i}));
      end else if (ran_we_state_o) begin
        host_seen(1'b0, ran_w_addr_state_o, 32'(ran_w_data_state_o));
      end
      if (acc_we_inex_i) begin
        chk("acc_inex_pass", 64'({ran_we_InexRecur_o, ran_w_addr_InexRecur_o, ran_w_data_InexRecur_o}),
            64'({1'b1, acc_waddr_inex_i, acc_wdata_inex_i}));
      end else if (ran_we_InexRecur_o) begin
        host_seen(1'b1, ran_w_addr_InexRecur_o, ran_w_data_InexRecur_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic host_drive(input logic v, input logic sel, input logic [11:0] addr, input logic [31:0] data);
    host_wvalid_i = v;
    host_wsel_i   = sel;
    host_waddr_i  = addr;
    host_wdata_i  = data;
  endtask

  task automatic acc_state(input logic we, input logic [11:0] addr, input logic [17:0] data);
    acc_we_state_i    = we;
    acc_waddr_state_i = addr;
    acc_wdata_state_i = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    hw_t e;
    bit  exp_rdy [8];
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    acc_state(1'b0, 12'h0, 18'h0);
    acc_we_inex_i = 1'b0; acc_waddr_inex_i = '0; acc_wdata_inex_i = '0;
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    sample();
    chk("rst_we_state", ran_we_state_o, 0);
    chk("rst_we_inex", ran_we_InexRecur_o, 0);
    chk("rst_stall", acc_stall_o, 0);
    chk("rst_wready", host_wready_o, 1);
    chk("rst_pending", host_pending_o, 0);
    chk("rst_conflict", conflict_o, 0);
    tick();

    // Single host InexRecur write with idle accelerator
    host_drive(1'b1, 1'b1, 12'h005, 32'hDEADBEEF);
    hq.push_back('{sel: 1'b1, addr: 12'h005, data: 32'hDEADBEEF});
    sample();
    chk("simple_wready", host_wready_o, 1);
    chk("simple_no_same_cycle", ran_we_InexRecur_o, 0);
    tick();
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    sample();
    chk("simple_inex_we", ran_we_InexRecur_o, 1);
    chk("simple_pending1", host_pending_o, 1);
    tick();
    sample();
    chk("simple_pending0", host_pending_o, 0);
    tick();

    // Priority: state write blocked 3 cycles, lands in the 4th
    host_drive(1'b1, 1'b0, 12'h010, 32'hABC2A5A5);
    hq.push_back('{sel: 1'b0, addr: 12'h010, data: 32'hABC2A5A5});
    sample();
    tick();
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      acc_state(1'b1, 12'h020, 18'(32'h100 + i));
      sample();
      chk("prio_pending", host_pending_o, 1);
      tick();
    end
    acc_state(1'b0, 12'h0, 18'h0);
    sample();
    chk("prio_host_lands", ran_we_state_o, 1);
    tick();

    // Cross-file: InexRecur head drains while write-back owns the state port
    acc_state(1'b1, 12'h030, 18'h00003);
    host_drive(1'b1, 1'b1, 12'h0AA, 32'h12345678);
    hq.push_back('{sel: 1'b1, addr: 12'h0AA, data: 32'h12345678});
    sample();
    tick();
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    acc_state(1'b1, 12'h030, 18'h00004);
    sample();
    chk("cross_state_we", ran_we_state_o, 1);
    chk("cross_inex_we", ran_we_InexRecur_o, 1);
    tick();
    acc_state(1'b0, 12'h0, 18'h0);

    // FIFO full: 5 pushes against a blocked state port; 5th waits for a slot
    for (int k = 0; k <= 10; k++) begin
      int idx;
      idx = (k > 4) ? 4 : k;
      acc_state(k <= 5, 12'h040, 18'(32'h50 + k));
      e = '{sel: 1'b0, addr: 12'(32'h100 + idx), data: 32'h0000_1000 + 32'(idx)};
      host_drive(k <= 7, e.sel, e.addr, e.data);
      if (k <= 7 && exp_rdy[k]) hq.push_back(e);
      sample();
      if (k <= 7) chk($sformatf("full_wready_k%0d", k), host_wready_o, exp_rdy[k]);
      if (k == 4) chk("full_pending_k4", host_pending_o, 4);
      if (k == 6) chk("full_pending_k6", host_pending_o, 4);
      if (k == 7) chk("full_pending_k7", host_pending_o, 3);
      tick();
    end
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    acc_state(1'b0, 12'h0, 18'h0);
    sample();
    chk("full_drained", host_pending_o, 0);
    tick();

    // Starvation, stall honoured
    for (int i = 0; i <= 10; i++) begin
      acc_state(i >= 1 && i <= 8, 12'h0E0, 18'(32'h180 + i));
      if (i == 0) begin
        host_drive(1'b1, 1'b0, 12'h077, 32'h0001_1111);
        hq.push_back('{sel: 1'b0, addr: 12'h077, data: 32'h0001_1111});
      end else begin
        host_drive(1'b0, 1'b0, 12'h0, 32'h0);
      end
      sample();
      if (i == 8) chk("starve_no_early_stall", acc_stall_o, 0);
      if (i == 9) begin
        chk("starve_stall", acc_stall_o, 1);
        chk("starve_drain", ran_we_state_o, 1);
      end
      if (i == 10) begin
        chk("starve_stall_one_cycle", acc_stall_o, 0);
        chk("starve_pending0", host_pending_o, 0);
        chk("starve_no_conflict", conflict_o, 0);
      end
      tick();
    end

    // Starvation, stall ignored: conflict, head kept, counter restarts
    for (int i = 0; i <= 19; i++) begin
      acc_state(i >= 1 && i <= 17, 12'h0F0, 18'(32'h200 + i));
      if (i == 0) begin
        host_drive(1'b1, 1'b0, 12'h088, 32'h0002_2222);
        hq.push_back('{sel: 1'b0, addr: 12'h088, data: 32'h0002_2222});
      end else begin
        host_drive(1'b0, 1'b0, 12'h0, 32'h0);
      end
      sample();
      if (i == 9) begin
        chk("ign_stall", acc_stall_o, 1);
        chk("ign_conflict_before", conflict_o, 0);
      end
      if (i == 10) begin
        chk("ign_conflict", conflict_o, 1);
        chk("ign_pending", host_pending_o, 1);
        chk("ign_stall_off", acc_stall_o, 0);
      end
      if (i == 17) chk("ign_restart_no_stall", acc_stall_o, 0);
      if (i == 18) begin
        chk("ign_stall2", acc_stall_o, 1);
        chk("ign_drain", ran_we_state_o, 1);
      end
      if (i == 19) chk("ign_pending0", host_pending_o, 0);
      tick();
    end

    // Reset mid-drain: queued writes are discarded and never appear
    for (int i = 0; i <= 3; i++) begin
      acc_state(1'b1, 12'h0C0, 18'(32'h300 + i));
      host_drive(i <= 2, 1'b0, 12'(32'h300 + i), 32'h0003_0000 + 32'(i));
      sample();
      if (i == 3) chk("mid_pending3", host_pending_o, 3);
      tick();
    end
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    acc_state(1'b0, 12'h0, 18'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sample();
    chk("mid_rst_pending", host_pending_o, 0);
    chk("mid_rst_wready", host_wready_o, 1);
    chk("mid_rst_conflict", conflict_o, 0);
    chk("mid_rst_stall", acc_stall_o, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      sample();
    end
    chk("mid_rst_still_empty", host_pending_o, 0);
    chk("scoreboard_empty", 64'(hq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the random-access write ports of regfile_state (18-bit) and regfile_InexRecur (32-bit) between two requesters: the accelerator write-back stage and a host loader (initial seeding and patching).
- Write-back writes cannot be back-pressured, so they always win.
- Host writes are queued in a small FIFO and drained into idle port cycles.
- A starvation counter asks the accelerator FSM to stall for one cycle when the host has waited too long.

Parameters:
- FIFO_DEPTH, 4, host write queue entries (power of 2, >=2).
- STARVE_MAX, 8, blocked cycles of the FIFO head before a stall request is raised.
- AW, 12, regfile address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- acc_we_state_i  in  1  write-back random write enable, state file
- acc_waddr_state_i  in  AW  write-back address, state file
- acc_wdata_state_i  in  18  write-back data, state file
- acc_we_inex_i  in  1  write-back random write enable, InexRecur file
- acc_waddr_inex_i  in  AW  write-back address, InexRecur file
- acc_wdata_inex_i  in  32  write-back data, InexRecur file
- host_wvalid_i  in  1  host write request
- host_wready_o  out  1  host request accepted this cycle when high together with valid
- host_wsel_i  in  1  target file: 0 = state, 1 = InexRecur
- host_waddr_i  in  AW  host address
- host_wdata_i  in  32  host data; bits [17:0] are used for the state file
- ran_we_state_o  out  1  to regfile_state
- ran_w_addr_state_o  out  AW  to regfile_state
- ran_w_data_state_o  out  18  to regfile_state
- ran_we_InexRecur_o  out  1  to regfile_InexRecur
- ran_w_addr_InexRecur_o  out  AW  to regfile_InexRecur
- ran_w_data_InexRecur_o  out  32  to regfile_InexRecur
- acc_stall_o  out  1  request to the accelerator FSM to hold for one cycle (no write-back)
- host_pending_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- conflict_o  out  1  sticky; set when write-back writes during a granted stall cycle

Behaviour:
- Reset: FIFO empty, starvation counter 0, FSM in IDLE.
  - All outputs 0 except host_wready_o = 1.
- Reset mid-operation discards queued host writes.
- Accelerator path:
  - Combinational, zero latency, always has priority.
  - acc_we_*_i drives ran_we_*_o, with address and data passed through, in the same cycle.
- Host path:
  - host_wready_o = !full.
  - Push occurs on host_wvalid_i && host_wready_o.
  - No push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: occupancy unchanged.
- Drain:
  - Strictly in order; only the FIFO head is eligible.
  - The head is "free" when the accelerator is not writing its target file this cycle.
  - If free: the head drives the target port combinationally and is popped at the clock edge.
  - A head targeting the other file never blocks on the unrelated write enable.
- Latency: a host write accepted in cycle N appears on the port no earlier than cycle N+1.
- Address collision between an accelerator write and the FIFO head: the accelerator write wins and the host write lands later. Ordering is host software's responsibility; no merging.
- FSM states:
  - IDLE: FIFO empty, counter 0. Goes to DRAIN on push.
  - DRAIN: head pending.
    - Pop with FIFO becoming empty -> IDLE.
    - Pop with FIFO still non-empty: counter cleared, stay in DRAIN.
    - Head blocked: counter += 1.
    - Counter reaches STARVE_MAX -> STALL_REQ.
  - STALL_REQ: acc_stall_o = 1 for exactly one cycle; this cycle the head is granted unconditionally.
    - If the accelerator still writes the same file, the accelerator wins, the head is not popped and conflict_o is set.
    - The counter clears either way.
    - Next state: DRAIN if the FIFO is non-empty, else IDLE.
- The counter saturates at STARVE_MAX and never wraps.
- acc_stall_o is registered (Moore output of STALL_REQ).
- conflict_o clears only on rst.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, DRAIN, STALL_REQ).
  - Widths: STATE_DW = 18, INEX_DW = 32, AW = 12.
  - File-select constants SEL_STATE = 0, SEL_INEX = 1.
- One sub-module: wr_fifo, a synchronous FIFO with first-word fall-through.
  - Entry is {sel, addr, data[31:0]}.
  - Outputs full, empty, count.
- The arbitration mux and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles.
  -> all ran_we_* = 0, acc_stall_o = 0, host_wready_o = 1, host_pending_o = 0.
- Host write with the accelerator idle: push {sel=1, addr=0x005, data=0xDEADBEEF}.
  -> next cycle ran_we_InexRecur_o = 1 with addr 0x005 and that data.
  -> host_pending_o returns to 0.
- Priority and cross-file drain:
  - Stimulus: queue a write to state 0x010 and hold acc_we_state_i = 1 (addr 0x020) for 3 cycles, with acc_we_inex_i = 0.
    -> state port carries the accelerator writes for those 3 cycles; the host write lands in cycle 4.
  - Stimulus: queue an InexRecur write while the accelerator writes state.
    -> both ports are written in the same cycle.
- FIFO full: push 5 back-to-back while the accelerator blocks the state file continuously.
  -> host_wready_o drops after 4 accepts; host_pending_o = 4; the 5th is held until a pop.
- Starvation: the accelerator writes the state file every cycle and one host state write is queued.
  -> acc_stall_o pulses one cycle after 8 blocked cycles.
  -> if the bench honours it (acc_we_state_i = 0), the head drains in that cycle.
  -> if not, conflict_o = 1, the head is still queued and the counter restarts.
- Reset mid-drain: 3 entries queued, assert rst.
  -> FIFO empty, no host write ever appears, FSM in IDLE, conflict_o = 0.
